checksum_accum: RTL and testbench

//  Streaming 16-bit ones'-complement (RFC 1071) checksum over a multi-word packet.

---
 rtl/checksum_accum_if.sv | 69 ++++++
 rtl/checksum_accum.sv | 200 ++++++++++++++++++++
 tb/tb_checksum_accum.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/checksum_accum_if.sv
// ---------------------------------------------------------------------------
// checksum_accum_if
//
// Purpose:
//    Bundles the input word stream and the result handshake of
//    checksum_accum into one interface.
//
// Modports:
//    slave  - the checksum block.
//    master - the packet source and result consumer that drive it.
//
// Signals:
//    in_data   [DATA_W]  packet word, [31:16] = hi half, [15:0] = lo half
//    in_valid  [1]       in_data/in_last valid
//    in_ready  [1]       checksum block can take a word this cycle
//    in_last   [1]       final word of the packet
//    out_csum  [16]      complemented ones'-complement sum of the packet
//    out_words [CNT_W]   words accepted in the packet (saturating)
//    out_valid [1]       result valid, held until out_ready
//    out_ready [1]       consumer takes the result
//    busy      [1]       packet partially accumulated
//    out_ok    [1]       packet verifies against its own checksum
//                        (only when CHECKSUM_VERIFY_EN is defined)
//
// Configuration macro: CHECKSUM_VERIFY_EN adds the out_ok signal.
// ---------------------------------------------------------------------------
interface checksum_accum_if #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 10
);

   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic              in_last;
   logic [15:0]       out_csum;
   logic [CNT_W-1:0]  out_words;
   logic              out_valid;
   logic              out_ready;
   logic              busy;
`ifdef CHECKSUM_VERIFY_EN
   logic              out_ok;
`endif

   // The slave side is the checksum block: it takes the stream and the
   // consumer's ready, and drives everything else back.
`ifdef CHECKSUM_VERIFY_EN
   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, out_csum, out_words, out_valid, busy, out_ok
   );

   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, out_csum, out_words, out_valid, busy, out_ok
   );
`else
   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, out_csum, out_words, out_valid, busy
   );

   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, out_csum, out_words, out_valid, busy
   );
`endif

endinterface

// File: rtl/checksum_accum.sv
// ---------------------------------------------------------------------------
// checksum_accum
//
// Purpose:
//    Streaming 16-bit ones'-complement checksum (RFC 1071 style) over a
//    multi-word packet. Each accepted 32-bit word contributes its two 16-bit
//    halves, folded into the accumulator with end-around carry in a single
//    cycle. When the last word is accepted, the complemented sum and the
//    saturating word count are registered and presented until consumed.
//
// Ports:
//    clk    in   single clock, all state on the rising edge
//    rst_n  in   asynchronous, active-low reset
//    bus    slave modport of checksum_accum_if:
//              in_data/in_valid/in_last/in_ready  word stream
//              out_csum/out_words/out_valid/out_ready  result handshake
//              busy  packet partially accumulated
//              out_ok  self-verification flag (CHECKSUM_VERIFY_EN only)
//
// Configuration macro:
//    CHECKSUM_VERIFY_EN - when defined, out_ok reports whether the packet's
//    final sum is 0xFFFF, i.e. a packet that carries its own checksum
//    verifies. When undefined the compare logic is not built.
// ---------------------------------------------------------------------------
module checksum_accum #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 10
) (
   input logic             clk,
   input logic             rst_n,
   checksum_accum_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t            state;
   state_t            state_next;

   logic [15:0]       acc;
   logic [CNT_W-1:0]  cnt;
   logic [15:0]       csum_q;
   logic [CNT_W-1:0]  words_q;

   logic              in_ready_c;
   logic              out_valid_c;
   logic              busy_c;
   logic              beat;

   logic [15:0]       half_hi;
   logic [15:0]       half_lo;
   logic [17:0]       sum_wide;
   logic [16:0]       sum_fold;
   logic [15:0]       acc_next;
   logic [CNT_W-1:0]  cnt_next;

`ifdef CHECKSUM_VERIFY_EN
   logic              ok_q;
`endif

   // A word is consumed only when both sides agree; in_data and in_last
   // are ignored on every other cycle.
   assign beat = bus.in_valid & in_ready_c;

   // Ones'-complement add of both halves to the accumulator. Adding two
   // 16-bit values to a 16-bit accumulator can carry at most 2 into bit 16,
   // so the first fold can itself carry once more; the second fold
   // absorbs that, and the result is guaranteed to fit in 16 bits.
   always_comb begin
      half_hi  = bus.in_data[DATA_W-1 -: 16];
      half_lo  = bus.in_data[15:0];
      sum_wide = {2'b00, acc} + {2'b00, half_hi} + {2'b00, half_lo};
      sum_fold = {1'b0, sum_wide[15:0]} + {15'd0, sum_wide[17:16]};
      acc_next = sum_fold[15:0] + {15'd0, sum_fold[16]};
   end

   // The word counter sticks at all-ones so very long packets still report
   // a meaningful (saturated) length instead of wrapping.
   always_comb begin
      cnt_next = cnt;
      if (cnt != {CNT_W{1'b1}}) begin
         cnt_next = cnt + CNT_ONE;
      end
   end

   // State register. Reset returns to IDLE from anywhere, discarding both a
   // partial packet and a result that has not been consumed yet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. IDLE and ACCUM behave identically on a beat; they
   // differ only in whether a packet is already in flight. DONE waits for
   // the consumer and never accepts a word, which costs one bubble per
   // packet but keeps the result stable and the accumulator clean.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE, ACCUM: begin
            if (beat) begin
               state_next = bus.in_last ? DONE : ACCUM;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Handshake and status outputs are decoded from the state alone, so
   // in_ready never depends combinationally on in_valid or out_ready.
   always_comb begin
      in_ready_c  = 1'b1;
      out_valid_c = 1'b0;
      busy_c      = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready_c = 1'b1;
         end
         ACCUM: begin
            busy_c = 1'b1;
         end
         DONE: begin
            in_ready_c  = 1'b0;
            out_valid_c = 1'b1;
         end
         default: begin
            in_ready_c = 1'b1;
         end
      endcase
   end

   // Accumulator and word counter. They advance on every accepted beat and
   // are cleared on the same edge the result is consumed, so the next
   // packet always starts from zero. Outside DONE, the only way to leave
   // IDLE is a beat, so acc and cnt are zero whenever the state is IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= 16'd0;
         cnt <= '0;
      end else if (state == DONE) begin
         if (bus.out_ready) begin
            acc <= 16'd0;
            cnt <= '0;
         end
      end else if (beat) begin
         acc <= acc_next;
         cnt <= cnt_next;
      end
   end

   // Result registers are loaded straight from the next-sum values on the
   // last beat, which makes the result visible the cycle after in_last is
   // accepted and keeps it frozen for as long as the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csum_q  <= 16'd0;
         words_q <= '0;
      end else if (beat && bus.in_last) begin
         csum_q  <= ~acc_next;
         words_q <= cnt_next;
      end
   end

`ifdef CHECKSUM_VERIFY_EN
   // A packet that already contains its own checksum sums to 0xFFFF
   // (negative zero). The flag is captured alongside out_csum and is only
   // meaningful while out_valid is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ok_q <= 1'b0;
      end else if (beat && bus.in_last) begin
         ok_q <= (acc_next == 16'hFFFF);
      end
   end

   assign bus.out_ok = ok_q;
`endif

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.busy      = busy_c;
   assign bus.out_csum  = csum_q;
   assign bus.out_words = words_q;

endmodule

// File: tb/tb_checksum_accum.sv
// ---------------------------------------------------------------------------
// tb_checksum_accum
//
// Purpose:
//    Directed, self-checking bench for checksum_accum. Inputs change on the
//    falling edge and outputs are checked on the following falling edge, so
//    every check sees the state after exactly one rising edge.
//
// Configuration macro: CHECKSUM_VERIFY_EN enables the out_ok vectors.
// ---------------------------------------------------------------------------
module tb_checksum_accum;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 10;

   logic clk;
   logic rst_n;

   int   vec_count;
   int   miscompares;

   checksum_accum_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

   checksum_accum #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive all stream and handshake inputs in one go.
   task automatic applyStimulus(input logic [31:0] data, input logic valid,
                                input logic last, input logic rdy);
      bus.in_data   = data;
      bus.in_valid  = valid;
      bus.in_last   = last;
      bus.out_ready = rdy;
   endtask

   // One rising edge, then back to the falling edge for checking/driving.
   task automatic stepCycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vec_count++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Offer one word for a single cycle, then idle the stream with junk data.
   task automatic sendWord(input logic [31:0] data, input logic last);
      applyStimulus(data, 1'b1, last, 1'b0);
      stepCycle();
      applyStimulus(32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
   endtask

   // Accept the pending result and check that the block is back in IDLE.
   task automatic consumeResult(input string tag);
      applyStimulus(32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
      stepCycle();
      applyStimulus(32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
      checkOutput({tag, "_drop_valid"}, {31'd0, bus.out_valid}, 32'd0);
      checkOutput({tag, "_ready_back"}, {31'd0, bus.in_ready}, 32'd1);
   endtask

   // Check a presented result: valid, checksum, word count, no input accepted.
   task automatic checkResult(input string tag, input logic [15:0] csum,
                              input logic [CNT_W-1:0] words);
      checkOutput({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
      checkOutput({tag, "_csum"},  {16'd0, bus.out_csum},  {16'd0, csum});
      checkOutput({tag, "_words"}, {22'd0, bus.out_words}, {22'd0, words});
      checkOutput({tag, "_inrdy"}, {31'd0, bus.in_ready},  32'd0);
   endtask

   initial begin
      vec_count   = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);

      // Reset values while rst_n is held low.
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_valid", {31'd0, bus.out_valid}, 32'd0);
      checkOutput("rst_busy",  {31'd0, bus.busy},      32'd0);
      checkOutput("rst_csum",  {16'd0, bus.out_csum},  32'd0);
      checkOutput("rst_words", {22'd0, bus.out_words}, 32'd0);
      checkOutput("rst_inrdy", {31'd0, bus.in_ready},  32'd1);
      rst_n = 1'b1;
      stepCycle();

      // Single-word packet: 0x9D2D + 0xC3D5 = 0x16102 -> 0x6103 -> ~ 0x9EFC.
      sendWord(32'h9D2D_C3D5, 1'b1);
      checkResult("one_word", 16'h9EFC, 10'd1);
      checkOutput("one_word_busy", {31'd0, bus.busy}, 32'd0);
      consumeResult("one_word");

      // Two words with carries: 0x0001 then 0x0002 -> ~ 0xFFFD.
      sendWord(32'h8000_8000, 1'b0);
      checkOutput("carry_busy",   {31'd0, bus.busy},      32'd1);
      checkOutput("carry_nvalid", {31'd0, bus.out_valid}, 32'd0);
      sendWord(32'h8000_8000, 1'b1);
      checkResult("carry", 16'hFFFD, 10'd2);
      consumeResult("carry");

      // Plain sum without carries: 1+2+3+4 = 0x000A -> ~ 0xFFF5.
      sendWord(32'h0001_0002, 1'b0);
      sendWord(32'h0003_0004, 1'b1);
      checkResult("plain", 16'hFFF5, 10'd2);
      consumeResult("plain");

      // Ones'-complement zeros: 0xFFFF sum -> 0x0000, zero sum -> 0xFFFF.
      sendWord(32'hFFFF_FFFF, 1'b1);
      checkResult("all_ones", 16'h0000, 10'd1);
      consumeResult("all_ones");
      sendWord(32'h0000_0000, 1'b1);
      checkResult("all_zero", 16'hFFFF, 10'd1);

      // Back-pressure in DONE: a valid word waits, result stays frozen.
      applyStimulus(32'h1234_5678, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         stepCycle();
         checkResult("hold", 16'hFFFF, 10'd1);
      end
      applyStimulus(32'h1234_5678, 1'b1, 1'b1, 1'b1);
      stepCycle();
      checkOutput("hold_release_valid", {31'd0, bus.out_valid}, 32'd0);
      checkOutput("hold_release_inrdy", {31'd0, bus.in_ready},  32'd1);
      applyStimulus(32'h9D2D_C3D5, 1'b1, 1'b1, 1'b0);
      stepCycle();
      applyStimulus(32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
      checkResult("after_hold", 16'h9EFC, 10'd1);
      consumeResult("after_hold");

      // Idle gaps inside a packet: state and sum hold across in_valid=0.
      sendWord(32'h8000_8000, 1'b0);
      applyStimulus(32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
      stepCycle();
      stepCycle();
      checkOutput("gap_busy",   {31'd0, bus.busy},      32'd1);
      checkOutput("gap_nvalid", {31'd0, bus.out_valid}, 32'd0);
      sendWord(32'h8000_8000, 1'b1);
      checkResult("gap", 16'hFFFD, 10'd2);
      consumeResult("gap");

      // Reset in the middle of a packet discards the partial sum.
      sendWord(32'h1111_2222, 1'b0);
      sendWord(32'h1111_2222, 1'b0);
      checkOutput("midrst_busy_before", {31'd0, bus.busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_busy",   {31'd0, bus.busy},      32'd0);
      checkOutput("midrst_nvalid", {31'd0, bus.out_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      stepCycle();
      sendWord(32'h9D2D_C3D5, 1'b1);
      checkResult("midrst_next", 16'h9EFC, 10'd1);

      // Reset while a result is pending discards it.
      rst_n = 1'b0;
      #1;
      checkOutput("donerst_valid", {31'd0, bus.out_valid}, 32'd0);
      checkOutput("donerst_csum",  {16'd0, bus.out_csum},  32'd0);
      checkOutput("donerst_words", {22'd0, bus.out_words}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      stepCycle();

      // Counter saturation: 1025 zero words report 1023 words, sum 0xFFFF.
      for (int i = 0; i < 1024; i++) begin
         sendWord(32'h0000_0000, 1'b0);
      end
      sendWord(32'h0000_0000, 1'b1);
      checkResult("saturate", 16'hFFFF, 10'd1023);
      consumeResult("saturate");

`ifdef CHECKSUM_VERIFY_EN
      // Packet carrying its own checksum: 0x6103 + 0x9EFC = 0xFFFF.
      sendWord(32'h9D2D_C3D5, 1'b0);
      sendWord(32'h0000_9EFC, 1'b1);
      checkResult("verify_ok", 16'h0000, 10'd2);
      checkOutput("verify_ok_flag", {31'd0, bus.out_ok}, 32'd1);
      consumeResult("verify_ok");

      // Off by one: 0x6103 + 0x9EFD = 0x10000 -> 0x0001 -> ~ 0xFFFE.
      sendWord(32'h9D2D_C3D5, 1'b0);
      sendWord(32'h0000_9EFD, 1'b1);
      checkResult("verify_bad", 16'hFFFE, 10'd2);
      checkOutput("verify_bad_flag", {31'd0, bus.out_ok}, 32'd0);
      consumeResult("verify_bad");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule
